// File: rtl/pcie_tx_skp_inserter_pkg.sv
// rtl/pcie_tx_skp_inserter_pkg.sv - symbol constants and FSM state type for the SKP inserter
package pcie_sym_pkg;
   localparam logic [7:0] SYM_COM  = 8'hBC;
   localparam logic [7:0] SYM_SKP  = 8'h1C;
   localparam logic [7:0] SYM_IDLE = 8'h00;

   typedef enum logic [1:0] {
      GAP = 2'd0,
      PKT = 2'd1,
      COM = 2'd2,
      SKP = 2'd3
   } tx_state_e;
endpackage

// File: rtl/pcie_tx_skp_inserter_if.sv
// rtl/pcie_tx_skp_inserter_if.sv - link-layer packet symbol stream into the SKP inserter
interface pcie_tx_skp_inserter_if;
   logic [7:0] in_data;
   logic       in_k;
   logic       in_valid;
   logic       in_sop;
   logic       in_eop;
   logic       in_ready;

   modport master (
      output in_data, in_k, in_valid, in_sop, in_eop,
      input  in_ready
   );

   modport slave (
      input  in_data, in_k, in_valid, in_sop, in_eop,
      output in_ready
   );
endinterface

// File: rtl/pcie_tx_skp_inserter_timer.sv
// rtl/pcie_tx_skp_inserter_timer.sv - saturating SKP interval counter; due holds until cleared
module skp_interval_timer #(
   parameter int SKP_INTERVAL = 1180,
   parameter int CNT_W        = 11
) (
   input  logic clk,
   input  logic rstb,
   input  logic clr,
   output logic due
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SKP_INTERVAL);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturation absorbs intervals that elapse while a SKP OS is already pending
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign due = (cnt_q == CNT_MAX);
endmodule

// File: rtl/pcie_tx_skp_inserter.sv
// rtl/pcie_tx_skp_inserter.sv - TX symbol source inserting SKP OS at packet gaps; SKP_STATS_EN adds skp_count
module pcie_tx_skp_inserter
   import pcie_sym_pkg::*;
#(
   parameter int SKP_INTERVAL = 1180,
   parameter int SKP_LEN      = 3,
   parameter int CNT_W        = 11
) (
   input  logic                         clk,
   input  logic                         rstb,
   pcie_tx_skp_inserter_if.slave        in_if,
   input  logic                         scram_dis_cfg,
   output logic [7:0]                   data_out,
   output logic                         k_out,
   output logic                         disab_scram,
   output logic                         skp_sent,
   output logic                         err_underrun
`ifdef SKP_STATS_EN
   ,
   output logic [15:0]                  skp_count
`endif
);
   localparam logic [2:0] IDX_LAST = 3'(SKP_LEN - 1);

   tx_state_e  state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] data_out_q, data_out_d;
   logic       k_out_q, k_out_d;
   logic       disab_scram_q, disab_scram_d;
   logic       skp_sent_q, skp_sent_d;
   logic       err_underrun_q, err_underrun_d;
   logic       skp_due;
   logic       cnt_clr;

   skp_interval_timer #(
      .SKP_INTERVAL(SKP_INTERVAL),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk (clk),
      .rstb(rstb),
      .clr (cnt_clr),
      .due (skp_due)
   );

   assign in_if.in_ready = rstb && ((state_q == PKT) || ((state_q == GAP) && !skp_due));

   // Each state decides the symbol that appears on data_out in the next cycle
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      data_out_d     = SYM_IDLE;
      k_out_d        = 1'b0;
      skp_sent_d     = 1'b0;
      err_underrun_d = err_underrun_q;
      disab_scram_d  = scram_dis_cfg;
      cnt_clr        = 1'b0;
      case (state_q)
         GAP: begin
            if (skp_due) begin
               data_out_d = SYM_COM;
               k_out_d    = 1'b1;
               skp_sent_d = 1'b1;
               cnt_clr    = 1'b1;
               state_d    = COM;
            end else if (in_if.in_valid) begin
               if (in_if.in_sop) begin
                  data_out_d = in_if.in_data;
                  k_out_d    = in_if.in_k;
                  if (!in_if.in_eop) begin
                     state_d = PKT;
                  end
               end else begin
                  err_underrun_d = 1'b1;
               end
            end
         end
         PKT: begin
            if (!in_if.in_valid || in_if.in_sop) begin
               err_underrun_d = 1'b1;
            end else begin
               data_out_d = in_if.in_data;
               k_out_d    = in_if.in_k;
               if (in_if.in_eop) begin
                  state_d = GAP;
               end
            end
         end
         COM: begin
            data_out_d = SYM_SKP;
            k_out_d    = 1'b1;
            idx_d      = 3'd1;
            state_d    = (SKP_LEN == 1) ? GAP : SKP;
         end
         SKP: begin
            data_out_d = SYM_SKP;
            k_out_d    = 1'b1;
            idx_d      = idx_q + 3'd1;
            if (idx_q == IDX_LAST) begin
               state_d = GAP;
            end
         end
         default: begin
            state_d = GAP;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q        <= GAP;
         idx_q          <= 3'd0;
         data_out_q     <= SYM_IDLE;
         k_out_q        <= 1'b0;
         disab_scram_q  <= 1'b0;
         skp_sent_q     <= 1'b0;
         err_underrun_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         data_out_q     <= data_out_d;
         k_out_q        <= k_out_d;
         disab_scram_q  <= disab_scram_d;
         skp_sent_q     <= skp_sent_d;
         err_underrun_q <= err_underrun_d;
      end
   end

   assign data_out     = data_out_q;
   assign k_out        = k_out_q;
   assign disab_scram  = disab_scram_q;
   assign skp_sent     = skp_sent_q;
   assign err_underrun = err_underrun_q;

`ifdef SKP_STATS_EN
   logic [15:0] skp_count_q, skp_count_d;

   // Advances together with skp_sent so the count already includes the COM on data_out
   always_comb begin
      skp_count_d = skp_count_q;
      if (skp_sent_d) begin
         skp_count_d = skp_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         skp_count_q <= 16'd0;
      end else begin
         skp_count_q <= skp_count_d;
      end
   end

   assign skp_count = skp_count_q;
`endif
endmodule

// File: tb/tb_pcie_tx_skp_inserter.sv
// tb/tb_pcie_tx_skp_inserter.sv - directed bench for pcie_tx_skp_inserter (SKP_INTERVAL=16, SKP_LEN=3)
module tb_pcie_tx_skp_inserter;
   logic       clk = 1'b0;
   logic       rstb;
   logic       scram_dis_cfg;
   logic [7:0] data_out;
   logic       k_out;
   logic       disab_scram;
   logic       skp_sent;
   logic       err_underrun;
`ifdef SKP_STATS_EN
   logic [15:0] skp_count;
`endif
   int total = 0;
   int bad   = 0;

   pcie_tx_skp_inserter_if bus ();

   pcie_tx_skp_inserter #(
      .SKP_INTERVAL(16),
      .SKP_LEN     (3),
      .CNT_W       (11)
   ) dut (
      .clk          (clk),
      .rstb         (rstb),
      .in_if        (bus),
      .scram_dis_cfg(scram_dis_cfg),
      .data_out     (data_out),
      .k_out        (k_out),
      .disab_scram  (disab_scram),
      .skp_sent     (skp_sent),
      .err_underrun (err_underrun)
`ifdef SKP_STATS_EN
      ,
      .skp_count    (skp_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic s, input logic e, input logic kk, input logic [7:0] d);
      bus.in_valid = v;
      bus.in_sop   = s;
      bus.in_eop   = e;
      bus.in_k     = kk;
      bus.in_data  = d;
   endtask

   // Advance to 1 time unit after the next rising edge: cycle c = after edge c+1 from release
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rstb = 1'b0;
      scram_dis_cfg = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge clk);
      @(posedge clk);
      #1;
      rstb = 1'b1;
   endtask

   task automatic test_reset;
      rstb = 1'b0;
      scram_dis_cfg = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
      #1;
      total++;
      if ({data_out, k_out, skp_sent, err_underrun, disab_scram} !== 12'h000) begin
         bad++;
         $display("FAIL reset_outputs got=%h/%b/%b/%b/%b want=00/0/0/0/0", data_out, k_out, skp_sent, err_underrun, disab_scram);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
      end
      total++;
      if (disab_scram !== 1'b0) begin
         bad++;
         $display("FAIL reset_disab_scram got=%b want=0", disab_scram);
      end
`ifdef SKP_STATS_EN
      total++;
      if (skp_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_skp_count got=%0d want=0", skp_count);
      end
`endif
   endtask

   task automatic test_idle_skp;
      logic [7:0] ed;
      logic       ek, es, er;
      do_reset();
      for (int c = 0; c < 22; c++) begin
         step();
         ed = 8'h00; ek = 1'b0; es = 1'b0;
         if (c == 16) begin
            ed = 8'hBC; ek = 1'b1; es = 1'b1;
         end else if (c >= 17 && c <= 19) begin
            ed = 8'h1C; ek = 1'b1;
         end
         er = !(c >= 15 && c <= 18);
         total++;
         if ({data_out, k_out, skp_sent, bus.in_ready} !== {ed, ek, es, er}) begin
            bad++;
            $display("FAIL idle_skp cyc=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", c, data_out, k_out, skp_sent, bus.in_ready, ed, ek, es, er);
         end
      end
   endtask

   task automatic test_packet_skp;
      logic [7:0] ed, sd;
      logic       ek, sk;
      int         i;
      do_reset();
      for (int c = 0; c < 56; c++) begin
         step();
         ed = 8'h00; ek = 1'b0;
         if (c >= 10 && c <= 49) begin
            i  = c - 10;
            ed = (i == 0) ? 8'hFB : (i == 39) ? 8'hFD : 8'(8'h40 + i);
            ek = (i == 0) || (i == 39);
         end else if (c == 50) begin
            ed = 8'hBC; ek = 1'b1;
         end else if (c >= 51 && c <= 53) begin
            ed = 8'h1C; ek = 1'b1;
         end
         total++;
         if ({data_out, k_out} !== {ed, ek}) begin
            bad++;
            $display("FAIL packet_skp cyc=%0d got=%h/%b want=%h/%b", c, data_out, k_out, ed, ek);
         end
         if (c >= 9 && c <= 48) begin
            total++;
            if (bus.in_ready !== 1'b1) begin
               bad++;
               $display("FAIL packet_ready cyc=%0d got=%b want=1", c, bus.in_ready);
            end
            i  = c - 9;
            sd = (i == 0) ? 8'hFB : (i == 39) ? 8'hFD : 8'(8'h40 + i);
            sk = (i == 0) || (i == 39);
            drive(1'b1, c == 9, c == 48, sk, sd);
         end else begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         end
      end
      total++;
      if (err_underrun !== 1'b0) begin
         bad++;
         $display("FAIL packet_err got=%b want=0", err_underrun);
      end
   endtask

   task automatic test_skp_wins;
      logic [7:0] ed;
      logic       ek, er;
      int         ptr;
      ptr = 0;
      do_reset();
      for (int c = 0; c < 24; c++) begin
         step();
         ed = 8'h00; ek = 1'b0;
         if (c == 16) begin
            ed = 8'hBC; ek = 1'b1;
         end else if (c >= 17 && c <= 19) begin
            ed = 8'h1C; ek = 1'b1;
         end else if (c == 20) begin
            ed = 8'h5A;
         end else if (c == 21) begin
            ed = 8'hA5;
         end
         er = !(c >= 15 && c <= 18);
         total++;
         if ({data_out, k_out, bus.in_ready} !== {ed, ek, er}) begin
            bad++;
            $display("FAIL skp_wins cyc=%0d got=%h/%b/%b want=%h/%b/%b", c, data_out, k_out, bus.in_ready, ed, ek, er);
         end
         if (c >= 15 && ptr < 2) begin
            drive(1'b1, ptr == 0, ptr == 1, 1'b0, (ptr == 0) ? 8'h5A : 8'hA5);
            if (bus.in_ready) ptr++;
         end else begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         end
      end
   endtask

   task automatic test_underrun;
      logic [7:0] ed;
      logic       ee;
      do_reset();
      for (int c = 0; c < 13; c++) begin
         step();
         ed = 8'h00;
         if (c == 3 || c == 4) ed = 8'(8'h60 + c - 3);
         else if (c >= 7 && c <= 10) ed = 8'(8'h60 + c - 5);
         ee = (c >= 5);
         total++;
         if ({data_out, k_out, err_underrun} !== {ed, 1'b0, ee}) begin
            bad++;
            $display("FAIL underrun cyc=%0d got=%h/%b/%b want=%h/0/%b", c, data_out, k_out, err_underrun, ed, ee);
         end
         if (c == 2 || c == 3) drive(1'b1, c == 2, 1'b0, 1'b0, 8'(8'h60 + c - 2));
         else if (c >= 6 && c <= 9) drive(1'b1, 1'b0, c == 9, 1'b0, 8'(8'h60 + c - 4));
         else drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      rstb = 1'b0;
      #1;
      total++;
      if (err_underrun !== 1'b0) begin
         bad++;
         $display("FAIL underrun_clear got=%b want=0", err_underrun);
      end
   endtask

   task automatic test_drop;
      logic [7:0] ed;
      logic       ee;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         step();
         ee = (c >= 3);
         total++;
         if ({data_out, k_out, err_underrun} !== {8'h00, 1'b0, ee}) begin
            bad++;
            $display("FAIL drop_gap cyc=%0d got=%h/%b/%b want=00/0/%b", c, data_out, k_out, err_underrun, ee);
         end
         if (c == 2) begin
            total++;
            if (bus.in_ready !== 1'b1) begin
               bad++;
               $display("FAIL drop_gap_ready got=%b want=1", bus.in_ready);
            end
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
         end else begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         end
      end
      do_reset();
      for (int c = 0; c < 7; c++) begin
         step();
         ed = (c == 3) ? 8'h31 : (c == 5) ? 8'h33 : 8'h00;
         ee = (c >= 4);
         total++;
         if ({data_out, k_out, err_underrun} !== {ed, 1'b0, ee}) begin
            bad++;
            $display("FAIL drop_pkt cyc=%0d got=%h/%b/%b want=%h/0/%b", c, data_out, k_out, err_underrun, ed, ee);
         end
         if (c == 2) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h31);
         else if (c == 3) drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h32);
         else if (c == 4) drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
         else drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] ed;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         step();
         ed = (c >= 3 && c <= 6) ? 8'(8'h42 + c - 3) : 8'h00;
         total++;
         if ({data_out, k_out, err_underrun} !== {ed, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL back_to_back cyc=%0d got=%h/%b/%b want=%h/0/0", c, data_out, k_out, err_underrun, ed);
         end
         if (c == 2) drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h42);
         else if (c == 3) drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h43);
         else if (c == 4) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h44);
         else if (c == 5) drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h45);
         else drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
   endtask

   task automatic test_reset_mid_skp;
      logic [7:0] ed;
      logic       ek, es;
      do_reset();
      for (int c = 0; c < 19; c++) step();
      total++;
      if ({data_out, k_out} !== {8'h1C, 1'b1}) begin
         bad++;
         $display("FAIL mid_skp_pre got=%h/%b want=1c/1", data_out, k_out);
      end
      rstb = 1'b0;
      #1;
      total++;
      if ({data_out, k_out, skp_sent} !== {8'h00, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL mid_skp_async got=%h/%b/%b want=00/0/0", data_out, k_out, skp_sent);
      end
      #3;
      rstb = 1'b1;
      for (int c = 0; c < 18; c++) begin
         step();
         ed = 8'h00; ek = 1'b0; es = 1'b0;
         if (c == 16) begin
            ed = 8'hBC; ek = 1'b1; es = 1'b1;
         end else if (c == 17) begin
            ed = 8'h1C; ek = 1'b1;
         end
         total++;
         if ({data_out, k_out, skp_sent} !== {ed, ek, es}) begin
            bad++;
            $display("FAIL mid_skp_after cyc=%0d got=%h/%b/%b want=%h/%b/%b", c, data_out, k_out, skp_sent, ed, ek, es);
         end
      end
   endtask

   task automatic test_scram_cfg;
      int pulses;
      pulses = 0;
      do_reset();
      for (int c = 0; c < 60; c++) begin
         step();
         if (skp_sent === 1'b1) pulses++;
         if (c == 2 || c == 3 || c == 5) begin
            total++;
            if (disab_scram !== (c == 3)) begin
               bad++;
               $display("FAIL scram_cfg cyc=%0d got=%b want=%b", c, disab_scram, c == 3);
            end
         end
         if (c == 2) scram_dis_cfg = 1'b1;
         if (c == 4) scram_dis_cfg = 1'b0;
      end
      total++;
      if (pulses != 3) begin
         bad++;
         $display("FAIL skp_pulses got=%0d want=3", pulses);
      end
`ifdef SKP_STATS_EN
      total++;
      if (skp_count !== 16'd3) begin
         bad++;
         $display("FAIL skp_count got=%0d want=3", skp_count);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_idle_skp();
      test_packet_skp();
      test_skp_wins();
      test_underrun();
      test_drop();
      test_back_to_back();
      test_reset_mid_skp();
      test_scram_cfg();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
